// File: rtl/fb_pkg.sv
// Shared types and geometry helpers for the frame-buffer write controller.
package fb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } fb_state_t;

  localparam int FRAMES_CNT_DEF = 3;
  typedef logic [$clog2(FRAMES_CNT_DEF)-1:0] buf_idx_t;

  // AXI bursts needed for one line: beats rounded up, then 256-beat bursts rounded up.
  function automatic int calc_bpl(input int line_size_b, input int data_width_b);
    int beats;
    beats = (line_size_b + data_width_b - 1) / data_width_b;
    return (beats + 255) / 256;
  endfunction

  function automatic int calc_frame_size(input int lines, input int stride_b);
    return lines * stride_b;
  endfunction

  function automatic int calc_exp_b(input int lines, input int bpl);
    return lines * bpl;
  endfunction

  // Values for the default 1080-line, 3840-byte, 64-bit geometry.
  localparam int FRAME_SIZE_B = calc_frame_size(1080, 4096);
  localparam int BPL          = calc_bpl(3840, 8);
  localparam int EXP_B        = calc_exp_b(1080, BPL);

endpackage

// File: rtl/fb_wr_buf_ctrl_buf_select.sv
// Picks the lowest buffer that is neither held by the reader nor the newest frame.
module fb_buf_select
  import fb_pkg::*;
#(
  parameter int FRAMES_CNT = 3,
  parameter int BUF_W      = $clog2(FRAMES_CNT)
) (
  input  logic [BUF_W-1:0] rd_buf_i,
  input  logic             rd_vld_i,
  input  logic [BUF_W-1:0] last_buf_i,
  input  logic             last_vld_i,
  output logic [BUF_W-1:0] next_buf_o
);

  // Scan downwards so the lowest eligible index is the one left standing.
  // The reader's buffer is only protected once it actually holds a frame.
  always_comb begin
    next_buf_o = '0;
    for (int i = FRAMES_CNT - 1; i >= 0; i--) begin
      if (!(rd_vld_i && (BUF_W'(i) == rd_buf_i)) &&
          !(last_vld_i && (BUF_W'(i) == last_buf_i))) begin
        next_buf_o = BUF_W'(i);
      end
    end
  end

endmodule

// File: rtl/fb_wr_buf_ctrl.sv
// Write-side frame buffer controller: line addresses, buffer rotation and B-response tracking.
module fb_wr_buf_ctrl
  import fb_pkg::*;
#(
  parameter int                    ADDR_WIDTH         = 32,
  parameter int                    DATA_WIDTH         = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter int                    FRAMES_CNT         = 3,
  parameter int                    LINES              = 1080,
  parameter int                    LINE_SIZE_B        = 3840,
  parameter int                    LINE_STRIDE_B      = 4096,
  parameter int                    MAX_PKT_SIZE_WIDTH = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          sof_i,
  input  logic                          eol_i,
  input  logic                          b_hs_i,
  input  logic                          rd_frame_start_i,
  output logic [ADDR_WIDTH-1:0]         addr_o,
  output logic [MAX_PKT_SIZE_WIDTH-1:0] pkt_size_o,
  output logic [$clog2(FRAMES_CNT)-1:0] wr_buf_o,
  output logic [$clog2(FRAMES_CNT)-1:0] rd_buf_o,
  output logic                          frame_avail_o,
  output logic                          short_frame_o,
  output logic                          overflow_o
);

  localparam int DATA_WIDTH_B    = DATA_WIDTH / 8;
  localparam int BUF_W           = $clog2(FRAMES_CNT);
  localparam int LC_W            = $clog2(LINES + 1);
  localparam int BURSTS_PER_LINE = calc_bpl(LINE_SIZE_B, DATA_WIDTH_B);
  localparam int FRAME_BURSTS    = calc_exp_b(LINES, BURSTS_PER_LINE);
  // Headroom above one frame: a replaced pending carries its outstanding count forward.
  localparam int BC_W            = $clog2(FRAME_BURSTS + 1) + 4;
  localparam logic [ADDR_WIDTH-1:0] FRAME_BYTES = ADDR_WIDTH'(calc_frame_size(LINES, LINE_STRIDE_B));
  localparam logic [ADDR_WIDTH-1:0] STRIDE      = ADDR_WIDTH'(LINE_STRIDE_B);

  fb_state_t         state_q;
  logic [BUF_W-1:0]  wr_buf_q, rd_buf_q, last_buf_q, pbuf_q;
  logic              avail_q, short_q, ovf_q, last_vld_q, pend_q, pub_q;
  logic [LC_W-1:0]   line_cnt_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [BC_W-1:0]   exp_b_q, b_cnt_q;

  logic [BUF_W-1:0]      next_buf;
  logic [ADDR_WIDTH-1:0] next_line0;
  logic                  b_done, publish, last_line, create, c_pub, carry;
  logic [BC_W-1:0]       c_exp;

  function automatic logic [ADDR_WIDTH-1:0] buf_base(input logic [BUF_W-1:0] b);
    return BASE_ADDR + ADDR_WIDTH'(b) * FRAME_BYTES;
  endfunction

  fb_buf_select #(
    .FRAMES_CNT (FRAMES_CNT),
    .BUF_W      (BUF_W)
  ) u_buf_select (
    .rd_buf_i   (rd_buf_q),
    .rd_vld_i   (avail_q),
    .last_buf_i (last_buf_q),
    .last_vld_i (last_vld_q),
    .next_buf_o (next_buf)
  );

  // Completion, frame-end detection and the zero-latency address mux.
  always_comb begin
    next_line0 = buf_base(next_buf);
    b_done     = pend_q && (b_cnt_q == exp_b_q);
    publish    = b_done && pub_q;
    carry      = pend_q && !b_done;
    last_line  = (line_cnt_q == LC_W'(LINES - 1));
    create     = (state_q == ST_ACTIVE) && (sof_i || (eol_i && last_line));
    c_pub      = !sof_i;
    c_exp      = sof_i ? BC_W'(int'(line_cnt_q) * BURSTS_PER_LINE) : BC_W'(FRAME_BURSTS);
    addr_o     = sof_i ? next_line0 : ptr_q;
  end

  assign pkt_size_o    = MAX_PKT_SIZE_WIDTH'(LINE_SIZE_B);
  assign wr_buf_o      = wr_buf_q;
  assign rd_buf_o      = rd_buf_q;
  assign frame_avail_o = avail_q;
  assign short_frame_o = short_q;
  assign overflow_o    = ovf_q;

  // Frame FSM, B accounting and reader handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_buf_q   <= '0;
      rd_buf_q   <= '0;
      last_buf_q <= '0;
      pbuf_q     <= '0;
      avail_q    <= 1'b0;
      short_q    <= 1'b0;
      ovf_q      <= 1'b0;
      last_vld_q <= 1'b0;
      pend_q     <= 1'b0;
      pub_q      <= 1'b0;
      line_cnt_q <= '0;
      ptr_q      <= BASE_ADDR;
      exp_b_q    <= '0;
      b_cnt_q    <= '0;
    end else begin
      short_q <= 1'b0;

      if (b_done) b_cnt_q <= BC_W'(b_hs_i);
      else        b_cnt_q <= b_cnt_q + BC_W'(b_hs_i);

      if (create) begin
        pend_q  <= 1'b1;
        pbuf_q  <= wr_buf_q;
        pub_q   <= c_pub;
        exp_b_q <= carry ? (c_exp + exp_b_q) : c_exp;
        if (carry) ovf_q <= 1'b1;
      end else if (b_done) begin
        pend_q <= 1'b0;
      end

      if (publish) begin
        last_buf_q <= pbuf_q;
        last_vld_q <= 1'b1;
      end

      if (rd_frame_start_i) begin
        if (publish) begin
          rd_buf_q <= pbuf_q;
          avail_q  <= 1'b1;
        end else if (last_vld_q) begin
          rd_buf_q <= last_buf_q;
          avail_q  <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (sof_i) begin
            state_q    <= ST_ACTIVE;
            wr_buf_q   <= next_buf;
            line_cnt_q <= '0;
            ptr_q      <= next_line0 + STRIDE;
          end else if (eol_i) begin
            ovf_q <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (sof_i) begin
            short_q    <= 1'b1;
            wr_buf_q   <= next_buf;
            line_cnt_q <= '0;
            ptr_q      <= next_line0 + STRIDE;
          end else if (eol_i) begin
            line_cnt_q <= line_cnt_q + LC_W'(1);
            // Pointer stops at the last line so stray lines stay inside the buffer.
            if (line_cnt_q < LC_W'(LINES - 2)) ptr_q <= ptr_q + STRIDE;
            if (last_line) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_wr_buf_ctrl.sv
// Scoreboard bench for fb_wr_buf_ctrl with a frame-level reference model.
module tb_fb_wr_buf_ctrl;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int BASE = 0;
  localparam int FR   = 3;
  localparam int LN   = 4;
  localparam int LSB  = 2048;
  localparam int LST  = 4096;
  localparam int PW   = 12;
  localparam int BW   = $clog2(FR);
  localparam int BPLM = (((LSB + (DW / 8) - 1) / (DW / 8)) + 255) / 256;
  localparam int FS   = LN * LST;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          sof_i = 1'b0, eol_i = 1'b0, b_hs_i = 1'b0, rd_frame_start_i = 1'b0;
  logic [AW-1:0] addr_o;
  logic [PW-1:0] pkt_size_o;
  logic [BW-1:0] wr_buf_o, rd_buf_o;
  logic          frame_avail_o, short_frame_o, overflow_o;

  fb_wr_buf_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(AW'(BASE)), .FRAMES_CNT(FR),
    .LINES(LN), .LINE_SIZE_B(LSB), .LINE_STRIDE_B(LST), .MAX_PKT_SIZE_WIDTH(PW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sof_i(sof_i), .eol_i(eol_i), .b_hs_i(b_hs_i),
    .rd_frame_start_i(rd_frame_start_i), .addr_o(addr_o), .pkt_size_o(pkt_size_o),
    .wr_buf_o(wr_buf_o), .rd_buf_o(rd_buf_o), .frame_avail_o(frame_avail_o),
    .short_frame_o(short_frame_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int wr;
    int rd;
    bit avail;
    bit short_p;
    bit ovf;
  } st_t;

  logic [AW-1:0] exp_addr_q[$];
  st_t           exp_st_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: frames, the reader's grant and a running B tally.
  int m_wr, m_rd, m_last, m_pbuf, m_lines, b_owed;
  bit m_avail, m_lvld, m_active, m_started, m_ovf, m_short, m_pend, m_ppub;
  int b_total, sum_exp, m_target;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_buf();
    for (int i = 0; i < FR; i++)
      if (!(m_avail && i == m_rd) && !(m_lvld && i == m_last)) return i;
    return 0;
  endfunction

  function automatic logic [AW-1:0] line_addr(input int b, input int l);
    return AW'(BASE + b * FS + l * LST);
  endfunction

  function automatic void model_reset();
    m_wr = 0; m_rd = 0; m_last = 0; m_pbuf = 0; m_lines = 0; b_owed = 0;
    m_avail = 0; m_lvld = 0; m_active = 0; m_started = 0; m_ovf = 0;
    m_short = 0; m_pend = 0; m_ppub = 0;
    b_total = 0; sum_exp = 0; m_target = 0;
  endfunction

  function automatic void new_pending(input int b, input int nb, input bit pub);
    if (m_pend) m_ovf = 1;
    sum_exp += nb;
    m_target = sum_exp;
    m_pend = 1;
    m_pbuf = b;
    m_ppub = pub;
  endfunction

  function automatic void push_state();
    st_t s;
    s.wr = m_wr; s.rd = m_rd; s.avail = m_avail; s.short_p = m_short; s.ovf = m_ovf;
    exp_st_q.push_back(s);
  endfunction

  task automatic cycle(input bit s, input bit e, input bit b, input bit r);
    int  n;
    bit  done;
    sof_i = s; eol_i = e; b_hs_i = b; rd_frame_start_i = r;
    n = pick_buf();
    if (s) exp_addr_q.push_back(line_addr(n, 0));
    else if (e) begin
      if (m_active) exp_addr_q.push_back(line_addr(m_wr, (m_lines + 1 < LN - 1) ? m_lines + 1 : LN - 1));
      else          exp_addr_q.push_back(line_addr(m_wr, m_started ? LN - 1 : 0));
    end
    if (e && !s && m_active) b_owed += BPLM;
    if (b) b_owed--;
    done = m_pend && (b_total == m_target);
    if (done) begin
      m_pend = 0;
      if (m_ppub) begin m_last = m_pbuf; m_lvld = 1; end
    end
    if (r && m_lvld) begin m_rd = m_last; m_avail = 1; end
    b_total += int'(b);
    m_short = 0;
    if (s) begin
      if (m_active) begin
        m_short = 1;
        new_pending(m_wr, m_lines * BPLM, 0);
      end
      m_wr = n; m_lines = 0; m_active = 1; m_started = 1;
    end else if (e) begin
      if (m_active) begin
        m_lines++;
        if (m_lines == LN) begin
          new_pending(m_wr, LN * BPLM, 1);
          m_active = 0;
        end
      end else m_ovf = 1;
    end
    @(posedge clk_i);
    push_state();
    #1;
  endtask

  task automatic idle(input int n, input bit give_b);
    for (int i = 0; i < n; i++) cycle(0, 0, give_b && (b_owed > 0), 0);
  endtask

  task automatic do_reset();
    rst_i = 1; sof_i = 0; eol_i = 0; b_hs_i = 0; rd_frame_start_i = 0;
    model_reset();
    exp_st_q.delete();
    exp_addr_q.delete();
    push_state();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      push_state();
      #1;
    end
    rst_i = 0;
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      idle(1, 0);
      cycle(0, 1, 0, 0);
    end
  endtask

  // Monitor: addresses on each sof/eol beat, registered outputs every cycle.
  always @(negedge clk_i) begin
    logic [AW-1:0] ea;
    st_t es;
    if (!rst_i && (sof_i || eol_i)) begin
      if (exp_addr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL addr_q: beat with no expected address at %0t", $time);
      end else begin
        ea = exp_addr_q.pop_front();
        check("addr_o", addr_o, ea);
      end
    end
    if (exp_st_q.size() > 0) begin
      es = exp_st_q.pop_front();
      check("wr_buf_o", wr_buf_o, es.wr);
      check("rd_buf_o", rd_buf_o, es.rd);
      check("frame_avail_o", frame_avail_o, es.avail);
      check("short_frame_o", short_frame_o, es.short_p);
      check("overflow_o", overflow_o, es.ovf);
    end
  end

  initial begin
    int rot[4];
    rot[0] = 1; rot[1] = 2; rot[2] = 1; rot[3] = 2;
    model_reset();
    @(posedge clk_i); #1;
    do_reset();
    check("pkt_size_o", pkt_size_o, LSB);

    // full frame into buffer 0, then handed to the reader
    cycle(1, 0, 0, 0);
    check("t1_wr_buf", wr_buf_o, 0);
    lines(LN);
    idle(10, 1);
    cycle(0, 0, 0, 1);
    check("t1_rd_buf", rd_buf_o, 0);
    check("t1_avail", frame_avail_o, 1);

    // reader holds buffer 0: writes rotate over 1 and 2
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 0, 0);
      check("t2_rotation", wr_buf_o, rot[k]);
      lines(LN);
      idle(8, 1);
    end

    // truncated frame is never published
    cycle(1, 0, 0, 0);
    lines(2);
    cycle(1, 0, 0, 0);
    check("t3_short_pulse", short_frame_o, 1);
    idle(8, 1);
    cycle(0, 0, 0, 1);
    check("t3_rd_not_short", rd_buf_o, 2);
    lines(LN);
    idle(8, 1);

    // stray line after a complete frame
    do_reset();
    cycle(1, 0, 0, 0);
    lines(LN);
    check("t4_no_ovf_yet", overflow_o, 0);
    cycle(0, 1, 0, 0);
    check("t4_overflow", overflow_o, 1);
    idle(8, 1);

    // last B of frame n lags 50 cycles behind frame n+1's sof
    do_reset();
    cycle(1, 0, 0, 0);
    lines(LN);
    for (int i = 0; i < LN * BPLM - 1; i++) cycle(0, 0, 1, 0);
    b_owed = b_owed;
    cycle(1, 0, 0, 0);
    idle(48, 0);
    cycle(0, 0, 0, 1);
    check("t5_not_yet_avail", frame_avail_o, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    check("t5_rd_buf", rd_buf_o, 0);
    check("t5_avail", frame_avail_o, 1);
    lines(LN);
    idle(10, 1);

    // reset in the middle of line 2
    do_reset();
    cycle(1, 0, 0, 0);
    lines(2);
    idle(2, 1);
    do_reset();
    cycle(1, 0, 0, 0);
    check("t6_wr_buf_after_rst", wr_buf_o, 0);
    lines(LN);
    idle(8, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit s, e, b, r;
      s = ($urandom_range(0, 99) < 3);
      e = !s && ($urandom_range(0, 99) < (m_active ? 25 : 1));
      b = (b_owed > 0) && ($urandom_range(0, 99) < 80);
      r = ($urandom_range(0, 99) < 5);
      cycle(s, e, b, r);
    end
    idle(30, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
